// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants, request payload and loader state types.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned KIND_W = 4;
  localparam int unsigned REG_W  = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [KIND_W-1:0] {
    K_R      = 4'd0,
    K_OPIMM  = 4'd1,
    K_LOAD   = 4'd2,
    K_STORE  = 4'd3,
    K_BRANCH = 4'd4,
    K_JAL    = 4'd5,
    K_JALR   = 4'd6,
    K_LUI    = 4'd7,
    K_AUIPC  = 4'd8
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  // Raw kind is kept as plain bits so illegal codes 9-15 stay representable.
  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [2:0]        funct3;
    logic              f7b5;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [XLEN-1:0]   imm;
  } enc_req_t;

endpackage

// File: rtl/rv_encode.sv
// Combinational RV32I field-level encoder; flags unknown kinds and misaligned branch/jump targets.
module rv_encode
  import rv_pkg::*;
(
  input  enc_req_t          req,
  output logic [XLEN-1:0]   word_c,
  output logic              illegal_c
);

  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (req.kind)
      K_R:
        word_c = {1'b0, req.f7b5, 5'b0, req.rs2, req.rs1, req.funct3, req.rd, OP_R};
      K_OPIMM: begin
        // Shift-immediate forms carry shamt plus the SRAI selector bit.
        if (req.funct3[1:0] == 2'b01)
          word_c = {1'b0, req.f7b5, 5'b0, req.imm[4:0], req.rs1, req.funct3, req.rd, OP_IMM};
        else
          word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_IMM};
      end
      K_LOAD:
        word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD};
      K_STORE:
        word_c = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], OP_STORE};
      K_BRANCH: begin
        illegal_c = req.imm[0];
        word_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                  req.imm[4:1], req.imm[11], OP_BRANCH};
      end
      K_JAL: begin
        illegal_c = req.imm[0];
        word_c = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, OP_JAL};
      end
      K_JALR:
        word_c = {req.imm[11:0], req.rs1, 3'b000, req.rd, OP_JALR};
      K_LUI:
        word_c = {req.imm[31:12], req.rd, OP_LUI};
      K_AUIPC:
        word_c = {req.imm[31:12], req.rd, OP_AUIPC};
      default:
        illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes handshaken field-level requests and writes them to consecutive
// instruction-memory words, one instruction per two cycles at most.
module instr_encoder_loader
  import rv_pkg::*;
#(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [AW-1:0]   base_addr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic            req_f7b5,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [31:0]     req_imm,
  output logic            im_we,
  output logic [AW-1:0]   im_addr,
  output logic [31:0]     im_wdata,
  output logic [AW:0]     count,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int unsigned CW = AW + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     word_q, word_d;
  logic            stop_seen_q, stop_seen_d;
  logic            req_ready_q, req_ready_d;
  logic            im_we_q, im_we_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  enc_req_t        enc_req;
  logic [31:0]     enc_word_c;
  logic            enc_illegal_c;
  logic [CW-1:0]   count_inc;

  assign enc_req = '{kind: req_kind, funct3: req_funct3, f7b5: req_f7b5,
                     rd: req_rd, rs1: req_rs1, rs2: req_rs2, imm: req_imm};

  rv_encode u_encode (
    .req       (enc_req),
    .word_c    (enc_word_c),
    .illegal_c (enc_illegal_c)
  );

  assign count_inc = count_q + CW'(1);

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    word_d      = word_q;
    stop_seen_d = stop_seen_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_ACCEPT;
          addr_d      = base_addr;
          count_d     = '0;
          stop_seen_d = 1'b0;
        end
      end
      S_ACCEPT: begin
        if (req_valid) begin
          if (enc_illegal_c) begin
            state_d = S_ERR;
          end else begin
            word_d      = enc_word_c;
            stop_seen_d = stop;
            state_d     = S_WRITE;
          end
        end else if (stop) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        addr_d      = addr_q + AW'(1);
        count_d     = count_inc;
        stop_seen_d = 1'b0;
        if (count_inc == CW'(DEPTH) || stop_seen_q || stop)
          state_d = S_DONE;
        else
          state_d = S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_ACCEPT);
    im_we_d     = (state_d == S_WRITE);
    busy_d      = (state_d == S_ACCEPT) || (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      word_q      <= '0;
      stop_seen_q <= 1'b0;
      req_ready_q <= 1'b0;
      im_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      stop_seen_q <= stop_seen_d;
      req_ready_q <= req_ready_d;
      im_we_q     <= im_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign req_ready = req_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = word_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
